// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - opcodes, sweep FSM states and mask-scan helper shared by the gate sweep block and its bench
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_BUF  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } op_sel_t;

  // Lowest set bit of mask at position >= from; from = 8 means none left.
  function automatic op_sel_t next_op(input logic [7:0] mask, input logic [3:0] from);
    op_sel_t r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        r.found = 1'b1;
        r.idx   = 3'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gate_eval.sv
// rtl/gate_eval.sv - combinational golden model of the eight gate opcodes
module gate_eval
  import gate_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_BUF:  y = a;
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - sweeps every selected gate opcode through all four operand pairs and
// records the sampled results against the golden table
module gate_sweep_ctrl
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  op_mask,
  output logic [2:0]  gate_op,
  output logic        gate_a,
  output logic        gate_b,
  input  logic        y_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] truth,
  output logic        err,
  output logic [4:0]  fail_idx
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t     state, state_d;
  logic [7:0] mask_q;
  logic [3:0] cnt;
  logic       load, sample, golden;
  op_sel_t    first_sel, next_sel;
  logic [4:0] vec_idx;

  assign first_sel = next_op(op_mask, 4'd0);
  assign next_sel  = next_op(mask_q, {1'b0, gate_op} + 4'd1);
  assign vec_idx   = {gate_op, gate_a, gate_b};
  assign busy      = (state == ST_DRIVE) || (state == ST_SAMPLE);
  assign done      = (state == ST_DONE);

  gate_eval u_golden (
    .op (gate_op),
    .a  (gate_a),
    .b  (gate_b),
    .y  (golden)
  );

  always_comb begin
    state_d = state;
    load    = 1'b0;
    sample  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = first_sel.found ? ST_DRIVE : ST_DONE;
        end
      end
      ST_DRIVE: begin
        if (cnt == SETTLE_M1) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        sample  = 1'b1;
        state_d = ({gate_a, gate_b} == 2'b11 && !next_sel.found) ? ST_DONE : ST_DRIVE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= (state == ST_DRIVE && state_d == ST_DRIVE) ? cnt + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q   <= '0;
      gate_op  <= '0;
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
      truth    <= '0;
      err      <= 1'b0;
      fail_idx <= '0;
    end else begin
      if (load) begin
        mask_q   <= op_mask;
        truth    <= '0;
        err      <= 1'b0;
        fail_idx <= '0;
        if (first_sel.found) begin
          gate_op <= first_sel.idx;
          gate_a  <= 1'b0;
          gate_b  <= 1'b0;
        end
      end
      if (sample) begin
        truth[vec_idx] <= y_in;
        if ((y_in != golden) && !err) begin
          err      <= 1'b1;
          fail_idx <= vec_idx;
        end
        // The final vector of the sweep stays on the outputs until the next start.
        if ({gate_a, gate_b} != 2'b11) begin
          {gate_a, gate_b} <= {gate_a, gate_b} + 2'd1;
        end else if (next_sel.found) begin
          gate_op <= next_sel.idx;
          gate_a  <= 1'b0;
          gate_b  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - self-checking bench for gate_sweep_ctrl: directed table, corner sequences,
// randomized masks and datapath faults against a truth-table reference model
module tb_gate_sweep_ctrl;

  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  op_mask = '0;
  logic [2:0]  gate_op;
  logic        gate_a, gate_b, y_in, busy, done, err;
  logic [31:0] truth;
  logic [4:0]  fail_idx;
  logic [31:0] flip = '0;
  logic        gold1;

  logic        start3 = 1'b0;
  logic [7:0]  mask3 = '0;
  logic [2:0]  gate_op3;
  logic        gate_a3, gate_b3, y3, busy3, done3, err3;
  logic [31:0] truth3;
  logic [4:0]  fail_idx3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_sweep_ctrl #(.SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op_mask(op_mask),
    .gate_op(gate_op), .gate_a(gate_a), .gate_b(gate_b), .y_in(y_in),
    .busy(busy), .done(done), .truth(truth), .err(err), .fail_idx(fail_idx)
  );

  gate_eval u_dp1 (.op(gate_op), .a(gate_a), .b(gate_b), .y(gold1));
  assign y_in = gold1 ^ flip[{gate_op, gate_a, gate_b}];

  gate_sweep_ctrl #(.SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .op_mask(mask3),
    .gate_op(gate_op3), .gate_a(gate_a3), .gate_b(gate_b3), .y_in(y3),
    .busy(busy3), .done(done3), .truth(truth3), .err(err3), .fail_idx(fail_idx3)
  );

  gate_eval u_dp3 (.op(gate_op3), .a(gate_a3), .b(gate_b3), .y(y3));

  typedef struct {
    logic [7:0]  mask;
    logic [31:0] flip;
    logic [31:0] truth;
    logic        err;
    logic [4:0]  fidx;
    int          cycles;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int ref_gate(input int op, input int a, input int b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return 1 - a;
      3: return 1 - (a & b);
      4: return 1 - (a | b);
      5: return a;
      6: return a ^ b;
      default: return 1 - (a ^ b);
    endcase
  endfunction

  // Sweep visits indices in ascending order, so the first fault is the lowest faulty selected index.
  task automatic model(input logic [7:0] mask, input logic [31:0] fl, output logic [31:0] t,
                       output logic e, output logic [4:0] fi, output int cyc);
    int y;
    t = '0; e = 1'b0; fi = '0; cyc = 0;
    for (int op = 0; op < 8; op++) begin
      if (mask[op]) begin
        cyc += 8;
        for (int ab = 0; ab < 4; ab++) begin
          y = ref_gate(op, ab >> 1, ab & 1) ^ int'(fl[op*4+ab]);
          t[op*4+ab] = y[0];
          if (fl[op*4+ab] && !e) begin
            e  = 1'b1;
            fi = 5'(op*4+ab);
          end
        end
      end
    end
  endtask

  task automatic run_sweep(input logic [7:0] mask, input logic [31:0] flipv, input int poke,
                           output int lat, output int bcnt, output int dcnt);
    op_mask = mask; flip = flipv; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0; bcnt = 0; dcnt = 0;
    while (!done && lat < LIMIT) begin
      if (busy) bcnt++;
      start = (lat == poke);
      if (lat == poke) op_mask = ~mask;
      tick();
      lat++;
    end
    start = 1'b0;
    if (done) dcnt = 1;
    repeat (3) begin
      tick();
      if (done) dcnt++;
      if (busy) bcnt++;
    end
  endtask

  initial begin
    int lat, bcnt, dcnt, exp_cyc;
    logic [31:0] exp_t;
    logic        exp_e;
    logic [4:0]  exp_fi;
    logic [7:0]  m;
    logic [31:0] f;
    logic [4:0]  prev, cur;
    int run, runs, bad, b3, n, op_changes;
    logic [2:0]  first_op, last_op;

    vecs[0] = '{8'hFF, 32'h0000_0000, 32'h96C1_73E8, 1'b0, 5'd0, 64};
    vecs[1] = '{8'h01, 32'h0000_0008, 32'h0000_0000, 1'b1, 5'd3, 8};
    vecs[2] = '{8'h00, 32'h0000_0000, 32'h0000_0000, 1'b0, 5'd0, 0};
    vecs[3] = '{8'h44, 32'h0000_0000, 32'h0600_0300, 1'b0, 5'd0, 16};
    vecs[4] = '{8'h81, 32'h8000_0001, 32'h1000_0009, 1'b1, 5'd0, 16};

    repeat (2) tick();
    check("reset_outputs", {14'b0, gate_op, gate_a, gate_b, busy, done, err, fail_idx, 6'b0},
          32'h0);
    check("reset_truth", truth, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_sweep(vecs[i].mask, vecs[i].flip, -1, lat, bcnt, dcnt);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].cycles);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].cycles);
      check($sformatf("vec%0d_done_count", i), dcnt, 1);
      check($sformatf("vec%0d_truth", i), truth, vecs[i].truth);
      check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
      check($sformatf("vec%0d_fail_idx", i), {27'b0, fail_idx}, {27'b0, vecs[i].fidx});
    end

    // Start pulse and mask change while busy must neither restart nor queue a sweep.
    model(8'h12, 32'h0000_0000, exp_t, exp_e, exp_fi, exp_cyc);
    run_sweep(8'h12, 32'h0, 5, lat, bcnt, dcnt);
    check("midstart_busy_cycles", bcnt, exp_cyc);
    check("midstart_done_count", dcnt, 1);
    check("midstart_truth", truth, exp_t);

    // Reset in the 10th cycle of a full sweep.
    op_mask = 8'hFF; flip = '0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("pre_reset_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {14'b0, gate_op, gate_a, gate_b, busy, done, err, fail_idx, 6'b0},
          32'h0);
    check("async_reset_truth", truth, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    dcnt = 0; bcnt = 0;
    repeat (6) begin
      tick();
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    check("post_reset_no_done", dcnt, 0);
    check("post_reset_idle", bcnt, 0);
    run_sweep(8'hFF, 32'h0, -1, lat, bcnt, dcnt);
    check("post_reset_sweep_latency", lat, 64);
    check("post_reset_sweep_truth", truth, 32'h96C1_73E8);

    // SETTLE=3 instance: two gates, every operand vector held for SETTLE+1 cycles.
    mask3 = 8'h44; start3 = 1'b1;
    tick();
    start3 = 1'b0; mask3 = 8'h00;
    prev = {gate_op3, gate_a3, gate_b3};
    first_op = gate_op3; last_op = gate_op3;
    run = 0; runs = 0; bad = 0; b3 = 0; n = 0; op_changes = 0;
    while (!done3 && n < LIMIT) begin
      if (busy3) begin
        b3++;
        cur = {gate_op3, gate_a3, gate_b3};
        if (cur == prev) run++;
        else begin
          runs++;
          if (run != 4) bad++;
          if (cur[4:2] != prev[4:2]) begin
            op_changes++;
            last_op = cur[4:2];
          end
          prev = cur;
          run = 1;
        end
      end
      tick();
      n++;
    end
    runs++;
    if (run != 4) bad++;
    check("s3_busy_cycles", b3, 32);
    check("s3_vector_runs", runs, 8);
    check("s3_bad_hold_lengths", bad, 0);
    check("s3_first_op", {29'b0, first_op}, 32'd2);
    check("s3_last_op", {29'b0, last_op}, 32'd6);
    check("s3_op_changes", op_changes, 1);
    check("s3_truth", truth3, 32'h0600_0300);
    check("s3_err", {26'b0, err3, fail_idx3}, 32'h0);

    for (int r = 0; r < 20; r++) begin
      m = 8'($urandom);
      f = ($urandom_range(0, 2) == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
      model(m, f, exp_t, exp_e, exp_fi, exp_cyc);
      run_sweep(m, f, -1, lat, bcnt, dcnt);
      check($sformatf("rand%0d_latency", r), lat, exp_cyc);
      check($sformatf("rand%0d_truth", r), truth, exp_t);
      check($sformatf("rand%0d_err_fidx", r), {26'b0, err, fail_idx}, {26'b0, exp_e, exp_fi});
      check($sformatf("rand%0d_done_count", r), dcnt, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
